// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one sequential multiplier between N_REQ requesters.
// It latches the winner's operands, drives the multiplier's rst/start/busy handshake and
// returns the product with a one-cycle done pulse. Only one multiplication is in flight.
// Optional watchdog: define MUL_SHARE_ARB_TIMEOUT_EN to abort a stuck multiplication
// after TIMEOUT_CYC cycles (product forced to 0, sticky err_o).
module mul_share_arb #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*WIDTH-1:0]   a_bi,
  input  logic [N_REQ*WIDTH-1:0]   b_bi,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         done_o,
  output logic [2*WIDTH-1:0]       y_bo,
  output logic                     busy_o,
  output logic                     err_o,
  output logic                     mul_rst_o,
  output logic                     mul_start_o,
  output logic [WIDTH-1:0]         mul_a_bo,
  output logic [WIDTH-1:0]         mul_b_bo,
  input  logic                     mul_busy_i,
  input  logic [2*WIDTH-1:0]       mul_y_bi
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StLaunch, StSettle, StWait, StDone} state_e;

  state_e             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic [2*WIDTH-1:0] r_y;
  logic               r_busy;
  logic               r_mul_rst;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [IdxW-1:0]    r_k;
  logic [IdxW-1:0]    r_last;

  logic               w_any;
  logic [IdxW-1:0]    w_pick;
  logic [N_REQ-1:0]   w_pick_oh;
  logic               w_timeout;

  // Round-robin pick: first set request searching upward from last+1, wrapping.
  always_comb begin
    int unsigned j;
    j         = 0;
    w_any     = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      j = (32'(r_last) + i) % N_REQ;
      if (!w_any && req_i[IdxW'(j)]) begin
        w_any  = 1'b1;
        w_pick = IdxW'(j);
      end
    end
    w_pick_oh[w_pick] = 1'b1;
  end

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_cnt_hit;

  assign w_cnt_hit = (r_cnt == CntW'(TIMEOUT_CYC - 1));
  // Fires only when the FSM will actually take the abort path (a normal finish wins in WAIT).
  assign w_timeout = w_cnt_hit &&
                     ((r_state == StSettle) || ((r_state == StWait) && mul_busy_i));

  // Watchdog counter: cleared in LAUNCH, counts every SETTLE/WAIT cycle; sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == StLaunch) begin
        r_cnt <= '0;
      end else if ((r_state == StSettle) || (r_state == StWait)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign w_timeout          = 1'b0;
  assign err_o              = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_done      <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_mul_rst   <= 1'b1;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_k         <= '0;
      r_last      <= IdxW'(N_REQ - 1);
    end else begin
      r_done      <= '0;
      r_mul_start <= 1'b0;
      case (r_state)
        StIdle: begin
          r_mul_rst <= 1'b1;
          if (w_any) begin
            r_gnt       <= w_pick_oh;
            r_k         <= w_pick;
            r_mul_a     <= a_bi[w_pick*WIDTH +: WIDTH];
            r_mul_b     <= b_bi[w_pick*WIDTH +: WIDTH];
            r_mul_rst   <= 1'b0;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StLaunch;
          end
        end
        StLaunch: r_state <= StSettle;
        StSettle, StWait: begin
          // SETTLE ignores mul_busy_i: the multiplier raises busy one cycle after start.
          if (w_timeout || ((r_state == StWait) && !mul_busy_i)) begin
            r_y       <= w_timeout ? '0 : mul_y_bi;
            r_done    <= r_gnt;
            r_gnt     <= '0;
            r_last    <= r_k;
            r_mul_rst <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_state <= StWait;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign y_bo        = r_y;
  assign busy_o      = r_busy;
  assign mul_rst_o   = r_mul_rst;
  assign mul_start_o = r_mul_start;
  assign mul_a_bo    = r_mul_a;
  assign mul_b_bo    = r_mul_b;

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb with a behavioural sequential multiplier.
// Stimulus pushes expected {done one-hot, product}; a monitor pops on every done pulse.
module tb_mul_share_arb;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
  localparam int HANG_WAIT = 4;
`else
  localparam int HANG_WAIT = 40;
`endif

  typedef struct packed {
    logic [N-1:0]   oh;
    logic [2*W-1:0] y;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_bi, b_bi;
  logic [N-1:0]     gnt_o, done_o;
  logic [2*W-1:0]   y_bo;
  logic             busy_o, err_o, mul_rst_o, mul_start_o;
  logic [W-1:0]     mul_a_bo, mul_b_bo;
  logic             mul_busy;
  logic [2*W-1:0]   mul_y;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_exp    = 0;
  int   n_seen   = 0;
  int   n_start  = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t e_mon;

  // Multiplier model knobs
  int   m_lat  = 0;
  bit   m_hang = 1'b0;
  logic m_pend;
  int   m_cnt;

  mul_share_arb #(
    .N_REQ      (N),
    .WIDTH      (W),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .a_bi       (a_bi),
    .b_bi       (b_bi),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .y_bo       (y_bo),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .mul_rst_o  (mul_rst_o),
    .mul_start_o(mul_start_o),
    .mul_a_bo   (mul_a_bo),
    .mul_b_bo   (mul_b_bo),
    .mul_busy_i (mul_busy),
    .mul_y_bi   (mul_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sequential multiplier: busy rises one cycle after start and stays high m_lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0;
      m_pend   <= 1'b0;
      m_cnt    <= 0;
      mul_y    <= '0;
    end else if (mul_rst_o) begin
      mul_busy <= 1'b0;
      m_pend   <= 1'b0;
    end else if (mul_start_o) begin
      m_pend  <= m_hang || (m_lat > 0);
      m_cnt   <= m_lat;
      mul_y   <= {8'd0, mul_a_bo} * {8'd0, mul_b_bo};
      n_start <= n_start + 1;
    end else if (m_pend) begin
      mul_busy <= 1'b1;
      m_pend   <= 1'b0;
    end else if (mul_busy && !m_hang) begin
      if (m_cnt <= 1) mul_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] oh, input logic [2*W-1:0] y);
    exp_t e;
    e.oh = oh;
    e.y  = y;
    q.push_back(e);
    n_exp++;
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && (done_o != '0)) begin
      n_seen++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        e_mon = q.pop_front();
        check("done_onehot", 32'(done_o), 32'(e_mon.oh));
        check("done_y", 32'(y_bo), 32'(e_mon.y));
        check("gnt_clear_at_done", 32'(gnt_o), 32'd0);
      end
    end
  end

  task automatic wait_gnt(input int k, output int t);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o[k]) begin
        got = 1'b1;
        break;
      end
    end
    check("gnt_seen", 32'(got), 32'd1);
    t = cyc;
  endtask

  task automatic wait_done(input int k, input int bound, output int t);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_o[k]) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    t = cyc;
  endtask

  // One isolated operation by requester k with multiplier latency lat.
  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] y, input int lat);
    int t0, t1, s0;
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    @(negedge clk);
    a_bi[k*W +: W] = a;
    b_bi[k*W +: W] = b;
    m_lat = lat;
    push(oh, y);
    s0 = n_start;
    req[k] = 1'b1;
    wait_gnt(k, t0);
    check("gnt_onehot", 32'(gnt_o), 32'(oh));
    check("start_at_launch", 32'(mul_start_o), 32'd1);
    check("mul_rst_low", 32'(mul_rst_o), 32'd0);
    wait_done(k, 200, t1);
    req[k] = 1'b0;
    check("latency", 32'(t1 - t0), 32'(lat + 3));
    @(negedge clk);
    check("start_pulses", 32'(n_start - s0), 32'd1);
    check("busy_after_done", 32'(busy_o), 32'd0);
    check("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int t0, t1, cnt;
    rst_n = 1'b0;
    req   = '0;
    a_bi  = '0;
    b_bi  = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_y", 32'(y_bo), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_mul_rst", 32'(mul_rst_o), 32'd1);
    check("rst_mul_start", 32'(mul_start_o), 32'd0);
    check("rst_mul_a", 32'(mul_a_bo), 32'd0);
    check("rst_mul_b", 32'(mul_b_bo), 32'd0);
    rst_n = 1'b1;

    // Single request
    run_op(0, 8'd7, 8'd9, 16'd63, 2);

    // Boundaries
    run_op(0, 8'd255, 8'd255, 16'd65025, 0);
    run_op(0, 8'd0, 8'd255, 16'd0, 1);
    repeat (5) @(negedge clk);
    check("y_hold_idle", 32'(y_bo), 32'd0);
    check("idle_not_busy", 32'(busy_o), 32'd0);

    // Operand change and request drop during WAIT
    @(negedge clk);
    a_bi[7:0] = 8'd4;
    b_bi[7:0] = 8'd10;
    m_lat = 5;
    push(2'b01, 16'd40);
    req = 2'b01;
    wait_gnt(0, t0);
    repeat (3) @(negedge clk);
    a_bi[7:0] = 8'd9;
    req = 2'b00;
    check("mul_a_stable", 32'(mul_a_bo), 32'd4);
    check("busy_in_wait", 32'(busy_o), 32'd1);
    wait_done(0, 100, t1);

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
    // Watchdog abort of a hung multiplier
    @(negedge clk);
    a_bi[7:0] = 8'd6;
    b_bi[7:0] = 8'd7;
    m_hang = 1'b1;
    push(2'b01, 16'd0);
    req = 2'b01;
    wait_done(0, 100, t1);
    req = 2'b00;
    m_hang = 1'b0;
    check("err_set", 32'(err_o), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_o), 32'd1);
`endif

    // Hung multiplier then async reset during WAIT
    @(negedge clk);
    a_bi[7:0] = 8'd5;
    b_bi[7:0] = 8'd5;
    m_hang = 1'b1;
    req = 2'b01;
    wait_gnt(0, t0);
    repeat (HANG_WAIT) @(negedge clk);
    check("hang_busy", 32'(busy_o), 32'd1);
    check("hang_gnt", 32'(gnt_o), 32'd1);
    check("hang_mul_rst", 32'(mul_rst_o), 32'd0);
`ifndef MUL_SHARE_ARB_TIMEOUT_EN
    check("hang_no_err", 32'(err_o), 32'd0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_y", 32'(y_bo), 32'd0);
    check("arst_mul_rst", 32'(mul_rst_o), 32'd1);
    check("arst_mul_a", 32'(mul_a_bo), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    req = 2'b00;
    m_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 1 alone after reset
    run_op(1, 8'd11, 8'd12, 16'd132, 0);

    // Contention: both held, grants must alternate 0,1,0,1
    @(negedge clk);
    a_bi = {8'd200, 8'd3};
    b_bi = {8'd2, 8'd5};
    m_lat = 1;
    push(2'b01, 16'd15);
    push(2'b10, 16'd400);
    push(2'b01, 16'd15);
    push(2'b10, 16'd400);
    req = 2'b11;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_o != '0) cnt++;
      if (cnt == 4) break;
    end
    req = 2'b00;
    check("contention_ops", 32'(cnt), 32'd4);

    repeat (8) @(negedge clk);
    check("all_done_seen", 32'(n_seen), 32'(n_exp));
    check("queue_empty", 32'(q.size()), 32'd0);
    check("final_idle", 32'(busy_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
